// File: rtl/uart_tx.sv
// UART transmitter: start bit, N data bits LSB first, optional parity, M stop bits.
// Bit timing comes from a clock-enable divider in the clk domain; all outputs are registered.
module uart_tx #(
  parameter int unsigned N          = 8,
  parameter int unsigned M          = 1,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned CLK_FREQ   = 50000000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         tx_start,
  input  logic [N-1:0] data_in,
  output logic         tx,
  output logic         busy,
  output logic         tx_done
);

  localparam int unsigned Div  = CLK_FREQ / BAUD_RATE;
  localparam int unsigned CntW = (Div >= 2) ? $clog2(Div) : 1;
  localparam int unsigned BitW = $clog2(N + 1);

  localparam logic [CntW-1:0] CntMax  = CntW'(Div - 1);
  localparam logic [BitW-1:0] BitLast = BitW'(N - 1);
  localparam logic            StopLast = 1'(M - 1);
  localparam logic            ParOdd   = (PARITY_ODD != 0);
  localparam logic            ParEn    = (PARITY_EN != 0);

  if (Div < 2) begin : g_div_check
    $error("uart_tx: CLK_FREQ/BAUD_RATE must be at least 2");
  end
  if (N < 1 || N > 16) begin : g_n_check
    $error("uart_tx: N must be in 1..16");
  end
  if (M < 1 || M > 2) begin : g_m_check
    $error("uart_tx: M must be 1 or 2");
  end

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [BitW-1:0] bit_q;
  logic            stop_q;
  logic [N-1:0]    shift_q;
  logic            par_q;
  logic            tx_q;
  logic            busy_q;
  logic            done_q;
  logic            tick;

  // Bit boundary: the current bit has now been held for Div cycles.
  always_comb begin
    tick = (cnt_q == CntMax);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q != StIdle) begin
        cnt_q <= tick ? '0 : cnt_q + 1'b1;
      end
      case (state_q)
        StIdle: begin
          if (tx_start) begin
            shift_q <= data_in;
            par_q   <= (^data_in) ^ ParOdd;
            cnt_q   <= '0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= StStart;
          end
        end
        StStart: begin
          if (tick) begin
            tx_q    <= shift_q[0];
            shift_q <= shift_q >> 1;
            state_q <= StData;
          end
        end
        StData: begin
          if (tick) begin
            if (bit_q == BitLast) begin
              if (ParEn) begin
                tx_q    <= par_q;
                state_q <= StParity;
              end else begin
                tx_q    <= 1'b1;
                state_q <= StStop;
              end
            end else begin
              bit_q   <= bit_q + 1'b1;
              tx_q    <= shift_q[0];
              shift_q <= shift_q >> 1;
            end
          end
        end
        StParity: begin
          if (tick) begin
            tx_q    <= 1'b1;
            state_q <= StStop;
          end
        end
        StStop: begin
          if (tick) begin
            if (stop_q == StopLast) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= StIdle;
            end else begin
              stop_q <= stop_q + 1'b1;
            end
          end
        end
        default: begin
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign tx      = tx_q;
  assign busy    = busy_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: five instances cover 8N1, 8E1, 8O1, 8N2 and 5N1 at small dividers.
module tb_uart_tx;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  start_v = '0;
  logic [15:0] data_in = '0;
  logic [4:0]  tx_w, busy_w, done_w;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  // 0: 8N1 div10, 1: 8E1 div10, 2: 8O1 div10, 3: 8N2 div10, 4: 5N1 div4
  uart_tx #(.N(8), .M(1), .PARITY_EN(0), .PARITY_ODD(0), .BAUD_RATE(100), .CLK_FREQ(1000))
    u_8n1 (.clk(clk), .reset(reset), .tx_start(start_v[0]), .data_in(data_in[7:0]),
           .tx(tx_w[0]), .busy(busy_w[0]), .tx_done(done_w[0]));
  uart_tx #(.N(8), .M(1), .PARITY_EN(1), .PARITY_ODD(0), .BAUD_RATE(100), .CLK_FREQ(1000))
    u_8e1 (.clk(clk), .reset(reset), .tx_start(start_v[1]), .data_in(data_in[7:0]),
           .tx(tx_w[1]), .busy(busy_w[1]), .tx_done(done_w[1]));
  uart_tx #(.N(8), .M(1), .PARITY_EN(1), .PARITY_ODD(1), .BAUD_RATE(100), .CLK_FREQ(1000))
    u_8o1 (.clk(clk), .reset(reset), .tx_start(start_v[2]), .data_in(data_in[7:0]),
           .tx(tx_w[2]), .busy(busy_w[2]), .tx_done(done_w[2]));
  uart_tx #(.N(8), .M(2), .PARITY_EN(0), .PARITY_ODD(0), .BAUD_RATE(100), .CLK_FREQ(1000))
    u_8n2 (.clk(clk), .reset(reset), .tx_start(start_v[3]), .data_in(data_in[7:0]),
           .tx(tx_w[3]), .busy(busy_w[3]), .tx_done(done_w[3]));
  uart_tx #(.N(5), .M(1), .PARITY_EN(0), .PARITY_ODD(0), .BAUD_RATE(100), .CLK_FREQ(400))
    u_5n1 (.clk(clk), .reset(reset), .tx_start(start_v[4]), .data_in(data_in[4:0]),
           .tx(tx_w[4]), .busy(busy_w[4]), .tx_done(done_w[4]));

  // Expected line waveform: frame bits fb[0..nb-1] each held div samples, starting at sample off.
  function automatic logic [511:0] wave(input logic [31:0] fb, input int nb, input int div,
                                        input int off, input logic [511:0] base);
    logic [511:0] w;
    w = base;
    for (int i = 0; i < nb * div; i++) w[off + i] = fb[i / div];
    return w;
  endfunction

  function automatic logic [511:0] ones(input int off, input int len, input logic [511:0] base);
    logic [511:0] w;
    w = base;
    for (int i = 0; i < len; i++) w[off + i] = 1'b1;
    return w;
  endfunction

  function automatic logic [511:0] one_at(input int pos, input logic [511:0] base);
    logic [511:0] w;
    w = base;
    w[pos] = 1'b1;
    return w;
  endfunction

  task automatic kick(input int sel, input logic [15:0] data, input logic hold);
    @(negedge clk);
    data_in = data;
    start_v[sel] = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start_v[sel] = 1'b0;
  endtask

  // Sample j is taken on the falling edge after accepting edge + j.
  task automatic capture(input int sel, input int nsamp, input int inj_at,
                         input logic [15:0] inj_data, input logic inj_pulse,
                         output logic [511:0] otx, output logic [511:0] obusy,
                         output logic [511:0] odone);
    otx = '1;
    obusy = '0;
    odone = '0;
    for (int j = 0; j < nsamp; j++) begin
      @(negedge clk);
      otx[j] = tx_w[sel];
      obusy[j] = busy_w[sel];
      odone[j] = done_w[sel];
      if (j == inj_at) begin
        data_in = inj_data;
        start_v[sel] = 1'b1;
      end else if (inj_pulse && j == inj_at + 1) begin
        start_v[sel] = 1'b0;
      end
    end
    start_v[sel] = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    checks++;
    if (tx_w !== 5'b11111) $display("FAIL reset_tx: got %b expected 11111", tx_w);
    else passes++;
    checks++;
    if (busy_w !== 5'b00000) $display("FAIL reset_busy: got %b expected 00000", busy_w);
    else passes++;
    checks++;
    if (done_w !== 5'b00000) $display("FAIL reset_done: got %b expected 00000", done_w);
    else passes++;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_8n1;
    logic [511:0] otx, obusy, odone, etx, ebusy, edone;
    kick(0, 16'h00A5, 1'b0);
    capture(0, 102, -10, 16'h0, 1'b0, otx, obusy, odone);
    etx = wave({1'b1, 8'hA5, 1'b0}, 10, 10, 0, '1);
    ebusy = ones(0, 100, '0);
    edone = one_at(100, '0);
    checks++;
    if (otx !== etx) $display("FAIL 8n1_tx: got %h expected %h", otx, etx);
    else passes++;
    checks++;
    if (obusy !== ebusy) $display("FAIL 8n1_busy: got %h expected %h", obusy, ebusy);
    else passes++;
    checks++;
    if (odone !== edone) $display("FAIL 8n1_done: got %h expected %h", odone, edone);
    else passes++;
  endtask

  task automatic test_parity;
    logic [511:0] otx, obusy, odone, etx, ebusy, edone;
    int sel_t [4] = '{1, 2, 1, 2};
    logic [7:0] dat_t [4] = '{8'hA5, 8'hA5, 8'h01, 8'h01};
    logic par_t [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 4; k++) begin
      kick(sel_t[k], {8'h00, dat_t[k]}, 1'b0);
      capture(sel_t[k], 112, -10, 16'h0, 1'b0, otx, obusy, odone);
      etx = wave({1'b1, par_t[k], dat_t[k], 1'b0}, 11, 10, 0, '1);
      ebusy = ones(0, 110, '0);
      edone = one_at(110, '0);
      checks++;
      if (otx !== etx) $display("FAIL parity_tx[%0d]: got %h expected %h", k, otx, etx);
      else passes++;
      checks++;
      if (obusy !== ebusy) $display("FAIL parity_busy[%0d]: got %h expected %h", k, obusy, ebusy);
      else passes++;
      checks++;
      if (odone !== edone) $display("FAIL parity_done[%0d]: got %h expected %h", k, odone, edone);
      else passes++;
    end
  endtask

  task automatic test_ignore_busy;
    logic [511:0] otx, obusy, odone, etx, ebusy, edone;
    kick(0, 16'h0000, 1'b0);
    capture(0, 112, 30, 16'h00FF, 1'b1, otx, obusy, odone);
    etx = wave({1'b1, 8'h00, 1'b0}, 10, 10, 0, '1);
    ebusy = ones(0, 100, '0);
    edone = one_at(100, '0);
    checks++;
    if (otx !== etx) $display("FAIL ignore_tx: got %h expected %h", otx, etx);
    else passes++;
    checks++;
    if (obusy !== ebusy) $display("FAIL ignore_busy: got %h expected %h", obusy, ebusy);
    else passes++;
    checks++;
    if (odone !== edone) $display("FAIL ignore_done: got %h expected %h", odone, edone);
    else passes++;
  endtask

  task automatic test_back_to_back;
    logic [511:0] otx, obusy, odone, etx, ebusy, edone;
    kick(3, 16'h003C, 1'b1);
    capture(3, 222, 0, 16'h00C3, 1'b0, otx, obusy, odone);
    etx = wave({2'b11, 8'h3C, 1'b0}, 11, 10, 0, '1);
    etx = wave({2'b11, 8'hC3, 1'b0}, 11, 10, 111, etx);
    ebusy = ones(111, 110, ones(0, 110, '0));
    edone = one_at(221, one_at(110, '0));
    checks++;
    if (otx !== etx) $display("FAIL b2b_tx: got %h expected %h", otx, etx);
    else passes++;
    checks++;
    if (obusy !== ebusy) $display("FAIL b2b_busy: got %h expected %h", obusy, ebusy);
    else passes++;
    checks++;
    if (odone !== edone) $display("FAIL b2b_done: got %h expected %h", odone, edone);
    else passes++;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_async_reset;
    logic [511:0] otx, obusy, odone, etx, ebusy, edone;
    kick(0, 16'h0000, 1'b0);
    repeat (35) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (tx_w[0] !== 1'b1) $display("FAIL async_tx: got %b expected 1", tx_w[0]);
    else passes++;
    checks++;
    if (busy_w[0] !== 1'b0) $display("FAIL async_busy: got %b expected 0", busy_w[0]);
    else passes++;
    checks++;
    if (done_w[0] !== 1'b0) $display("FAIL async_done: got %b expected 0", done_w[0]);
    else passes++;
    @(negedge clk);
    reset = 1'b1;
    kick(0, 16'h005A, 1'b0);
    capture(0, 102, -10, 16'h0, 1'b0, otx, obusy, odone);
    etx = wave({1'b1, 8'h5A, 1'b0}, 10, 10, 0, '1);
    ebusy = ones(0, 100, '0);
    edone = one_at(100, '0);
    checks++;
    if (otx !== etx) $display("FAIL after_reset_tx: got %h expected %h", otx, etx);
    else passes++;
    checks++;
    if (obusy !== ebusy) $display("FAIL after_reset_busy: got %h expected %h", obusy, ebusy);
    else passes++;
    checks++;
    if (odone !== edone) $display("FAIL after_reset_done: got %h expected %h", odone, edone);
    else passes++;
  endtask

  task automatic test_n5;
    logic [511:0] otx, obusy, odone, etx, ebusy, edone;
    kick(4, 16'h0013, 1'b0);
    capture(4, 30, -10, 16'h0, 1'b0, otx, obusy, odone);
    etx = wave({1'b1, 5'b10011, 1'b0}, 7, 4, 0, '1);
    ebusy = ones(0, 28, '0);
    edone = one_at(28, '0);
    checks++;
    if (otx !== etx) $display("FAIL n5_tx: got %h expected %h", otx, etx);
    else passes++;
    checks++;
    if (obusy !== ebusy) $display("FAIL n5_busy: got %h expected %h", obusy, ebusy);
    else passes++;
    checks++;
    if (odone !== edone) $display("FAIL n5_done: got %h expected %h", odone, edone);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_ignore_busy();
    test_back_to_back();
    test_async_reset();
    test_n5();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
